jstk_poll_ctrl: RTL and testbench
=================================

// Module: jstk_poll_ctrl
// PURPOSE
//   Sequencer for PmodJSTK reads over a byte-level SPI master.
//   - Polls the joystick periodically and drives SS and byte-level SPI start.
//   - Sends the 5-byte command frame and collects the 5 returned bytes.
//   - Decodes X/Y/buttons into registered outputs with a 1-cycle valid strobe.
//   - Sits between the SPI byte engine and game/display logic on the 100 MHz clock.
// PARAMETERS
//   POLL_CYCLES      20_000_000  clocks between poll starts (5 Hz at 100 MHz)
//   SS_SETUP_CYCLES  1_500       SS-low to first byte start (15 us)
//   BYTE_GAP_CYCLES  1_000       done-to-next-start gap between bytes (10 us)
//   TIMEOUT_CYCLES   100_000     max wait for i_spi_done per byte
// PORTS
//   i_clk       in   1   system clock (100 MHz)
//   i_rst       in   1   synchronous reset, active-high
//   i_en        in   1   polling enable
//   i_led_cmd   in   2   PmodJSTK LED bits {LD2,LD1}, sampled at frame start
//   o_ss        out  1   slave select, active-low
//   o_spi_start out  1   1-cycle pulse: SPI master shifts o_spi_tx
//   o_spi_tx    out  8   byte to transmit
//   i_spi_done  in   1   1-cycle pulse: byte complete, i_spi_rx valid
//   i_spi_rx    in   8   received byte
//   o_x         out  10  joystick X position
//   o_y         out  10  joystick Y position
//   o_btn       out  3   {trigger, btn2, btn1}
//   o_valid     out  1   1-cycle pulse: o_x/o_y/o_btn just updated
//   o_err       out  1   1-cycle pulse: byte timeout, frame aborted
//   o_busy      out  1   high from SS assert through frame end
// BEHAVIOUR
//   Reset values:
//     o_ss=1; o_spi_start=0; o_spi_tx=0; o_x=0; o_y=0; o_btn=0;
//     o_valid=0; o_err=0; o_busy=0; poll counter=0; FSM=IDLE.
//   Reset mid-frame: o_ss=1 on the next edge; the partial frame is discarded.
//   Poll timer:
//     - Free-running counter 0..POLL_CYCLES-1; tick on the wrap cycle.
//     - Runs regardless of i_en.
//     - Ticks arriving while o_busy=1, or while i_en=0, are dropped. No queuing.
//   FSM:
//     - IDLE: tick & i_en -> SETUP.
//         Latch tx0={6'b100000,i_led_cmd}. Clear byte index.
//         o_ss=0 and o_busy=1 from this edge.
//     - SETUP: hold SS_SETUP_CYCLES clocks -> XFER.
//     - XFER: pulse o_spi_start for 1 cycle -> WAIT.
//         o_spi_tx = tx0 for index 0, else 8'h00.
//         o_spi_tx is held until done.
//     - WAIT, on i_spi_done:
//         store i_spi_rx into rx[idx].
//         idx<4: idx++ -> GAP.
//         idx==4 -> DONE.
//     - WAIT, no done for TIMEOUT_CYCLES -> ABORT.
//     - GAP: hold BYTE_GAP_CYCLES clocks -> XFER.
//     - DONE (1 cycle):
//         o_x={rx1[1:0],rx0}; o_y={rx3[1:0],rx2}; o_btn=rx4[2:0];
//         o_valid=1; o_ss=1 next edge; o_busy=0 next edge -> IDLE.
//     - ABORT (1 cycle): o_err=1; o_ss=1; outputs hold old values -> IDLE.
//   Signal rules:
//     - i_spi_done outside WAIT is ignored.
//     - i_spi_done in the same cycle as the timeout expiry counts as done.
//     - i_en deasserted mid-frame: the frame completes normally.
//     - i_led_cmd changes mid-frame are ignored until the next frame.
//     - o_valid and o_err are never high together.
//   Latency: tick to first o_spi_start = SS_SETUP_CYCLES+1 clocks.
//   Counter widths: $clog2(param)+1 bits; no overflow is possible.
// STRUCTURE
//   jstk_pkg:
//     - typedef enum {IDLE,SETUP,XFER,WAIT,GAP,DONE,ABORT} jstk_state_t
//     - JSTK_NUM_BYTES=5
//     - JSTK_CMD_PREFIX=6'b100000
//   Sub-module cycle_timer:
//     - load/count-down delay counter with expiry flag.
//     - Shared by SETUP, GAP and the timeout.
//   The poll timer is local to jstk_poll_ctrl.
// TESTING
//   (POLL=100, SETUP=4, GAP=3, TIMEOUT=50; SPI model returns done 8 clk after start)
//   1 i_en=1, led=2'b01; model rx=8'h34,02,8'h7F,01,05 ->
//     tx0=8'h81 then 00 x4; o_x=10'h234; o_y=10'h17F; o_btn=3'b101;
//     o_valid pulses once; o_ss low for the whole frame.
//   2 Measure tick->first start = 5 clk; each done->next start = 4 clk;
//     o_spi_start is exactly 1 cycle wide, 5 pulses per frame.
//   3 Model withholds done on byte 2 -> o_err pulses 50 clk after start;
//     o_ss=1; o_x/o_y unchanged; next tick runs a clean frame.
//   4 i_rst asserted during GAP -> next edge o_ss=1, o_busy=0, outputs 0;
//     no o_valid from the aborted frame.
//   5 i_en=0 across 3 ticks -> no start pulses, o_ss stays 1;
//     i_en dropped mid-frame -> that frame still completes with o_valid.
//   6 Spurious i_spi_done in IDLE and GAP -> ignored; byte index and outputs unchanged.

Source files
------------

// File: rtl/jstk_pkg.sv
// jstk_pkg: shared state encoding, frame constants and helpers for the PmodJSTK poller
package jstk_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, GAP, DONE, ABORT} jstk_state_t;
    localparam int JSTK_NUM_BYTES = 5;
    localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;
    function automatic logic [7:0] jstk_cmd(input logic [1:0] led);
        return {JSTK_CMD_PREFIX, led};
    endfunction
    function automatic int jstk_max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction
endpackage

// File: rtl/jstk_poll_ctrl_if.sv
// jstk_poll_ctrl_if: byte-level SPI handshake between the poller and the SPI master
interface jstk_poll_ctrl_if;
    logic       o_ss;
    logic       o_spi_start;
    logic [7:0] o_spi_tx;
    logic       i_spi_done;
    logic [7:0] i_spi_rx;
    modport master (output o_ss, o_spi_start, o_spi_tx, input i_spi_done, i_spi_rx);
    modport slave (input o_ss, o_spi_start, o_spi_tx, output i_spi_done, i_spi_rx);
endinterface

// File: rtl/cycle_timer.sv
// cycle_timer: loadable count-down delay counter, expired while the count sits at zero
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_expired
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_expired = r_cnt == '0;
endmodule

// File: rtl/jstk_poll_ctrl.sv
// jstk_poll_ctrl: periodic PmodJSTK reader sequencing 5-byte SPI frames and decoding X/Y/buttons
module jstk_poll_ctrl
    import jstk_pkg::*;
#(
    parameter int POLL_CYCLES     = 20_000_000,
    parameter int SS_SETUP_CYCLES = 1_500,
    parameter int BYTE_GAP_CYCLES = 1_000,
    parameter int TIMEOUT_CYCLES  = 100_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_led_cmd,
    jstk_poll_ctrl_if.master spi,
    output logic [9:0]       o_x,
    output logic [9:0]       o_y,
    output logic [2:0]       o_btn,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_busy
);
    localparam int PW = $clog2(POLL_CYCLES) + 1;
    localparam int TW = $clog2(jstk_max3(SS_SETUP_CYCLES, BYTE_GAP_CYCLES, TIMEOUT_CYCLES)) + 1;

    jstk_state_t   r_state, w_next;
    logic [PW-1:0] r_poll;
    logic [2:0]    r_idx;
    logic [7:0]    r_tx0, r_b0, r_b2;
    logic [1:0]    r_b1, r_b3;
    logic          w_tick, w_begin, w_take, w_last, w_active, w_load, w_exp;
    logic [TW-1:0] w_load_val;

    assign w_tick   = r_poll == PW'(POLL_CYCLES - 1);
    assign w_begin  = r_state == IDLE && w_tick && i_en;
    assign w_take   = r_state == WAIT && spi.i_spi_done;
    assign w_last   = r_idx == 3'(JSTK_NUM_BYTES - 1);
    assign w_active = r_state inside {SETUP, XFER, WAIT, GAP, DONE};

    cycle_timer #(.W(TW)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load),
        .i_val    (w_load_val),
        .o_expired(w_exp)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_poll  <= '0;
        end else begin
            r_state <= w_next;
            r_poll  <= w_tick ? '0 : r_poll + PW'(1);
        end
    end

    // The timeout is loaded from XFER so the window counts from the start pulse itself
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: begin
                w_load     = w_begin;
                w_load_val = TW'(SS_SETUP_CYCLES - 1);
                w_next     = w_begin ? SETUP : IDLE;
            end
            SETUP: w_next = w_exp ? XFER : SETUP;
            XFER: begin
                w_load     = 1'b1;
                w_load_val = TW'(TIMEOUT_CYCLES - 2);
                w_next     = WAIT;
            end
            WAIT: begin
                w_load     = spi.i_spi_done;
                w_load_val = TW'(BYTE_GAP_CYCLES - 1);
                w_next     = spi.i_spi_done ? (w_last ? DONE : GAP) : (w_exp ? ABORT : WAIT);
            end
            GAP: w_next = w_exp ? XFER : GAP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx <= '0;
            r_tx0 <= '0;
            r_b0  <= '0;
            r_b1  <= '0;
            r_b2  <= '0;
            r_b3  <= '0;
            o_x   <= '0;
            o_y   <= '0;
            o_btn <= '0;
        end else begin
            if (w_begin) begin
                r_tx0 <= jstk_cmd(i_led_cmd);
                r_idx <= '0;
            end
            if (w_take) begin
                r_idx <= r_idx + 3'd1;
                case (r_idx)
                    3'd0: r_b0 <= spi.i_spi_rx;
                    3'd1: r_b1 <= spi.i_spi_rx[1:0];
                    3'd2: r_b2 <= spi.i_spi_rx;
                    3'd3: r_b3 <= spi.i_spi_rx[1:0];
                    default: ;
                endcase
            end
            if (w_take && w_last) begin
                o_x   <= {r_b1, r_b0};
                o_y   <= {r_b3, r_b2};
                o_btn <= spi.i_spi_rx[2:0];
            end
        end
    end

    assign spi.o_ss        = !w_active;
    assign spi.o_spi_start = r_state == XFER;
    assign spi.o_spi_tx    = (r_state inside {XFER, WAIT} && r_idx == 3'd0) ? r_tx0 : 8'h00;
    assign o_valid         = r_state == DONE;
    assign o_err           = r_state == ABORT;
    assign o_busy          = w_active;
endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// tb_jstk_poll_ctrl: scoreboard bench with an SPI slave model answering 8 clocks after each start
module tb_jstk_poll_ctrl;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
    } res_t;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, spur = 1'b0;
    logic [1:0] led = 2'b00;
    logic [9:0] x, y;
    logic [2:0] btn;
    logic valid, err, busy;
    int cyc = 0, n_cmp = 0, n_bad = 0;
    res_t q_exp[$];
    logic [7:0] q_tx[$];

    int f_fall, f_valid_n, f_err_n, f_err_cyc, f_both, f_wide;
    int f_starts[$], f_dones[$];
    logic [7:0] f_tx[$];
    logic f_err_ss;
    bit f_ok, opt_drop_en = 0, opt_spur_gap = 0;
    res_t f_res;
    int t1_fall;

    logic [7:0] m_rx [5];
    int m_hold = -1, m_idx = 0, m_cnt = 0;
    bit m_busy = 0;
    logic m_done = 1'b0;
    logic [7:0] m_rxd = 8'h00;

    jstk_poll_ctrl_if bus();

    jstk_poll_ctrl #(
        .POLL_CYCLES(100), .SS_SETUP_CYCLES(4), .BYTE_GAP_CYCLES(3), .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_led_cmd(led), .spi(bus),
        .o_x(x), .o_y(y), .o_btn(btn), .o_valid(valid), .o_err(err), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.i_spi_done = m_done | spur;
    assign bus.i_spi_rx   = spur ? 8'hEE : m_rxd;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst || bus.o_ss) begin
            m_idx  <= 0;
            m_busy <= 0;
        end else if (bus.o_spi_start) begin
            m_busy <= 1;
            m_cnt  <= 1;
        end else if (m_busy) begin
            if (m_cnt == 7) begin
                m_busy <= 0;
                m_idx  <= m_idx + 1;
                if (m_idx != m_hold) begin
                    m_done <= 1'b1;
                    m_rxd  <= m_rx[m_idx];
                end
            end else m_cnt <= m_cnt + 1;
        end
    end

    task automatic load_frame(input logic [7:0] b0, b1, b2, b3, b4, input res_t want);
        m_rx = '{b0, b1, b2, b3, b4};
        q_exp.push_back(want);
    endtask

    task automatic capture(input int max_wait);
        int n, spur_at;
        bit prev_start;
        f_starts.delete(); f_dones.delete(); f_tx.delete();
        f_valid_n = 0; f_err_n = 0; f_both = 0; f_wide = 0; f_err_cyc = -1;
        f_err_ss = 1'b0; f_ok = 0; f_res = 'x; prev_start = 0; spur_at = -1; n = 0;
        @(negedge clk);
        while (bus.o_ss && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        if (bus.o_ss) return;
        f_fall = cyc;
        n = 0;
        while (n < 400) begin
            if (bus.o_spi_start) begin
                f_starts.push_back(cyc);
                f_tx.push_back(bus.o_spi_tx);
                if (prev_start) f_wide++;
                if (opt_drop_en) en = 1'b0;
            end
            prev_start = bus.o_spi_start;
            if (bus.i_spi_done && !spur) begin
                f_dones.push_back(cyc);
                if (opt_spur_gap && spur_at < 0) spur_at = cyc + 1;
            end
            spur = (cyc == spur_at);
            if (valid) begin
                f_valid_n++;
                f_res = {x, y, btn};
            end
            if (err) begin
                f_err_n++;
                f_err_cyc = cyc;
                f_err_ss = bus.o_ss;
            end
            if (valid && err) f_both++;
            if (bus.o_ss) break;
            @(negedge clk);
            n++;
        end
        spur = 1'b0;
        f_ok = bus.o_ss;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.o_ss !== 1'b1) begin n_bad++; $display("FAIL reset_ss: got %b want 1", bus.o_ss); end
        n_cmp++;
        if ({bus.o_spi_start, bus.o_spi_tx} !== 9'd0) begin
            n_bad++; $display("FAIL reset_spi: got start=%b tx=%h want 0/00", bus.o_spi_start, bus.o_spi_tx);
        end
        n_cmp++;
        if ({x, y, btn, valid, err, busy} !== 26'd0) begin
            n_bad++; $display("FAIL reset_outputs: got x=%h y=%h b=%b v=%b e=%b busy=%b want all 0", x, y, btn, valid, err, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_frame;
        logic [7:0] want_tx;
        res_t want;
        led = 2'b01;
        en = 1'b1;
        load_frame(8'h34, 8'h02, 8'h7F, 8'h01, 8'h05, '{10'h234, 10'h17F, 3'b101});
        q_tx.delete();
        q_tx.push_back(8'h81);
        repeat (4) q_tx.push_back(8'h00);
        capture(250);
        t1_fall = f_fall;
        n_cmp++;
        if (!f_ok) begin n_bad++; $display("FAIL t1_frame_seen: got no complete frame want one"); end
        n_cmp++;
        if (f_starts.size() != 5) begin n_bad++; $display("FAIL t1_start_count: got %0d want 5", f_starts.size()); end
        foreach (f_tx[i]) begin
            want_tx = q_tx.size() > 0 ? q_tx.pop_front() : 8'hxx;
            n_cmp++;
            if (f_tx[i] !== want_tx) begin n_bad++; $display("FAIL t1_tx%0d: got %h want %h", i, f_tx[i], want_tx); end
        end
        n_cmp++;
        if (f_valid_n != 1) begin n_bad++; $display("FAIL t1_valid_count: got %0d want 1", f_valid_n); end
        want = q_exp.pop_front();
        n_cmp++;
        if (f_res !== want) begin
            n_bad++; $display("FAIL t1_result: got x=%h y=%h b=%b want x=%h y=%h b=%b", f_res.x, f_res.y, f_res.b, want.x, want.y, want.b);
        end
    endtask

    task automatic test_timing;
        res_t want;
        int gap;
        led = 2'b10;
        load_frame(8'hFF, 8'h03, 8'h00, 8'h02, 8'h07, '{10'h3FF, 10'h200, 3'b111});
        capture(250);
        n_cmp++;
        if (f_fall - t1_fall != 100) begin n_bad++; $display("FAIL t2_poll_period: got %0d want 100", f_fall - t1_fall); end
        n_cmp++;
        gap = f_starts.size() > 0 ? f_starts[0] - f_fall : -1;
        if (gap != 4) begin n_bad++; $display("FAIL t2_ssfall_to_start: got %0d want 4 (tick to start 5)", gap); end
        for (int k = 1; k < 5; k++) begin
            gap = (k < f_starts.size() && k <= f_dones.size()) ? f_starts[k] - f_dones[k-1] : -1;
            n_cmp++;
            if (gap != 4) begin n_bad++; $display("FAIL t2_done_to_start%0d: got %0d want 4", k, gap); end
        end
        n_cmp++;
        if (f_wide != 0 || f_starts.size() != 5) begin
            n_bad++; $display("FAIL t2_start_pulses: got %0d pulses wide=%0d want 5 wide=0", f_starts.size(), f_wide);
        end
        n_cmp++;
        if (f_tx.size() == 0 || f_tx[0] !== 8'h82) begin n_bad++; $display("FAIL t2_tx0: got %h want 82", f_tx.size() ? f_tx[0] : 8'hxx); end
        want = q_exp.pop_front();
        n_cmp++;
        if (f_res !== want || f_valid_n != 1) begin
            n_bad++; $display("FAIL t2_result: got x=%h y=%h b=%b n=%0d want x=%h y=%h b=%b n=1", f_res.x, f_res.y, f_res.b, f_valid_n, want.x, want.y, want.b);
        end
    endtask

    task automatic test_abort;
        res_t want;
        int d;
        m_hold = 2;
        m_rx = '{8'h11, 8'h01, 8'h22, 8'h01, 8'h01};
        capture(250);
        d = f_starts.size() >= 3 ? f_err_cyc - f_starts[2] : -1;
        n_cmp++;
        if (f_err_n != 1 || d != 50) begin n_bad++; $display("FAIL t3_err_timing: got n=%0d dt=%0d want n=1 dt=50", f_err_n, d); end
        n_cmp++;
        if (f_err_ss !== 1'b1 || f_starts.size() != 3) begin
            n_bad++; $display("FAIL t3_abort_ss: got ss=%b starts=%0d want ss=1 starts=3", f_err_ss, f_starts.size());
        end
        n_cmp++;
        if (f_valid_n != 0 || f_both != 0) begin n_bad++; $display("FAIL t3_no_valid: got %0d valid %0d overlap want 0", f_valid_n, f_both); end
        n_cmp++;
        if ({x, y, btn} !== {10'h3FF, 10'h200, 3'b111}) begin
            n_bad++; $display("FAIL t3_hold_outputs: got x=%h y=%h b=%b want 3ff 200 111", x, y, btn);
        end
        m_hold = -1;
        load_frame(8'h00, 8'h01, 8'h55, 8'h03, 8'h02, '{10'h100, 10'h355, 3'b010});
        capture(250);
        want = q_exp.pop_front();
        n_cmp++;
        if (f_res !== want || f_valid_n != 1 || f_err_n != 0) begin
            n_bad++; $display("FAIL t3_recover: got x=%h y=%h b=%b v=%0d e=%0d want x=%h y=%h b=%b v=1 e=0", f_res.x, f_res.y, f_res.b, f_valid_n, f_err_n, want.x, want.y, want.b);
        end
    endtask

    task automatic test_reset_mid;
        int n, nv, nss;
        n = 0;
        while (bus.o_ss && n < 250) begin @(negedge clk); n++; end
        while (!bus.i_spi_done && n < 500) begin @(negedge clk); n++; end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || n >= 500) begin n_bad++; $display("FAIL t4_in_gap: got busy=%b waited=%0d want busy=1 in gap", busy, n); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_ss, busy, valid} !== 3'b100) begin n_bad++; $display("FAIL t4_ss_busy: got ss=%b busy=%b v=%b want 1 0 0", bus.o_ss, busy, valid); end
        n_cmp++;
        if ({x, y, btn} !== 23'd0) begin n_bad++; $display("FAIL t4_outputs_cleared: got x=%h y=%h b=%b want 0", x, y, btn); end
        rst = 1'b0;
        nv = 0;
        nss = 0;
        repeat (60) begin
            @(negedge clk);
            if (valid) nv++;
            if (!bus.o_ss) nss++;
        end
        n_cmp++;
        if (nv != 0 || nss != 0) begin n_bad++; $display("FAIL t4_no_resume: got %0d valid %0d ss-low want 0 0", nv, nss); end
    endtask

    task automatic test_enable;
        int nst, nss;
        res_t want;
        en = 1'b0;
        nst = 0;
        nss = 0;
        repeat (320) begin
            @(negedge clk);
            if (bus.o_spi_start) nst++;
            if (!bus.o_ss) nss++;
        end
        n_cmp++;
        if (nst != 0 || nss != 0) begin n_bad++; $display("FAIL t5_disabled: got %0d starts %0d ss-low want 0 0", nst, nss); end
        en = 1'b1;
        opt_drop_en = 1;
        load_frame(8'h12, 8'hFE, 8'hAB, 8'h00, 8'hF9, '{10'h212, 10'h0AB, 3'b001});
        capture(250);
        opt_drop_en = 0;
        want = q_exp.pop_front();
        n_cmp++;
        if (f_res !== want || f_valid_n != 1 || f_starts.size() != 5) begin
            n_bad++; $display("FAIL t5_en_drop_frame: got x=%h y=%h b=%b v=%0d s=%0d want x=%h y=%h b=%b v=1 s=5", f_res.x, f_res.y, f_res.b, f_valid_n, f_starts.size(), want.x, want.y, want.b);
        end
        en = 1'b1;
    endtask

    task automatic test_spurious;
        int nv, nss;
        res_t want;
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        nv = 0;
        nss = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) nv++;
            if (!bus.o_ss) nss++;
        end
        n_cmp++;
        if ({x, y, btn} !== {10'h212, 10'h0AB, 3'b001} || nv != 0 || nss != 0) begin
            n_bad++; $display("FAIL t6_idle_spurious: got x=%h y=%h b=%b v=%0d ssl=%0d want 212 0ab 001 0 0", x, y, btn, nv, nss);
        end
        opt_spur_gap = 1;
        load_frame(8'h9A, 8'h01, 8'h3C, 8'h02, 8'h06, '{10'h19A, 10'h23C, 3'b110});
        capture(250);
        opt_spur_gap = 0;
        n_cmp++;
        if (f_starts.size() != 5) begin n_bad++; $display("FAIL t6_gap_index: got %0d starts want 5", f_starts.size()); end
        want = q_exp.pop_front();
        n_cmp++;
        if (f_res !== want || f_valid_n != 1) begin
            n_bad++; $display("FAIL t6_gap_result: got x=%h y=%h b=%b v=%0d want x=%h y=%h b=%b v=1", f_res.x, f_res.y, f_res.b, f_valid_n, want.x, want.y, want.b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame();
        test_timing();
        test_abort();
        test_reset_mid();
        test_enable();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
